// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end.
// Owns the fetch PC and drives the instruction memory address.
// Captures {pc, instr} pairs into a small circular queue.
// Hands the queue head to decode over a valid/ready handshake.
// Execute redirects flush the queue and restart fetch at the target.
// A misaligned redirect target sets a sticky fault that stops fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_fault
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam cnt_t DEPTH_C = cnt_t'(QDEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    logic        fault_q, fault_d;
    entry_t      queue_q [QDEPTH];

    logic        pop;
    logic        push;

    assign imem_addr      = fetch_pc_q;
    assign out_valid      = (count_q != '0);
    assign out_pc         = queue_q[rd_ptr_q].pc;
    assign out_instr      = queue_q[rd_ptr_q].instr;
    assign out_pc_plus4   = out_pc + 32'd4;
    assign misalign_fault = fault_q;

    // Next-state logic: handshake, queue bookkeeping, redirect and fault.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fault_d    = fault_q;

        // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<=' below.
        pop  = out_valid & out_ready;
        push = ~fault_q & ~redirect_valid & ((count_q < DEPTH_C) | pop);

        if (redirect_valid) begin
            // The head popped this cycle was seen by decode; everything else is dropped.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (!fault_q) begin
                if (redirect_pc[1:0] == 2'b00) begin
                    fetch_pc_d = redirect_pc;
                end else begin
                    fault_d = 1'b1;
                end
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + ptr_t'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // Queue storage: write the fetched pair at the write pointer on push.
    // NOTE: the storage array is not reset; count_q gates its visibility, so its contents never matter while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// queue-based behavioural model of the fetch front end.
module tb_fetch_unit;

    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_fault;

    // Second instance exercising the PC wrap from a high reset PC.
    logic        reset2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic [31:0] out_pc_plus4_2;
    logic        misalign_fault2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] mpc;
    logic        mfault;
    ent_t        mq[$];

    // Instruction memory contents: a scrambled word derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    always_comb imem_rdata  = mem_word(imem_addr);
    always_comb imem_rdata2 = mem_word(imem_addr2);

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .misalign_fault (misalign_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QDEPTH)) dut_wrap (
        .clk            (clk),
        .reset          (reset2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .out_valid      (out_valid2),
        .out_ready      (1'b1),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2),
        .out_pc_plus4   (out_pc_plus4_2),
        .misalign_fault (misalign_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mpc    = 32'h0000_0000;
        mfault = 1'b0;
        mq.delete();
    endtask

    // One clock of the fetch rules, evaluated on the inputs about to be sampled.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic do_pop;
        logic do_push;
        do_pop  = (mq.size() != 0) && rdy;
        do_push = !mfault && !rv && ((mq.size() < QDEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            if (!mfault) begin
                if (rpc[1:0] == 2'b00) mpc = rpc;
                else                   mfault = 1'b1;
            end
        end else if (do_push) begin
            mq.push_back('{pc: mpc, instr: mem_word(mpc)});
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check("imem_addr", imem_addr, mpc);
        check("misalign_fault", {31'd0, misalign_fault}, {31'd0, mfault});
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
            check("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
        end
    endtask

    // Called at a falling edge: compare, drive, advance model, wait one cycle.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        check_outputs();
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        model_step(rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fault", {31'd0, misalign_fault}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        reset2         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        model_reset();
        @(negedge clk);

        // Free-running ready: 0x0, 0x4, 0x8 on consecutive cycles.
        apply_reset();
        check("rst_imem_addr", imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("seq_pc0", out_pc, 32'h0);
        check("seq_pc0_p4", out_pc_plus4, 32'h4);
        cycle(1'b0, 32'h0, 1'b1);
        check("seq_pc1", out_pc, 32'h4);
        cycle(1'b0, 32'h0, 1'b1);
        check("seq_pc2", out_pc, 32'h8);
        check("seq_pc2_p4", out_pc_plus4, 32'hC);
        cycle(1'b0, 32'h0, 1'b1);

        // Back-pressure: queue saturates at two, fetch_pc parks at 0x8.
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        check("bp_fetch_pc", imem_addr, 32'h8);
        check("bp_head", out_pc, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_after1", out_pc, 32'h4);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_after2", out_pc, 32'h8);
        cycle(1'b0, 32'h0, 1'b1);

        // Redirect against a full queue with a simultaneous pop.
        apply_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h14, 1'b1);
        check("redir_bubble", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("redir_target", out_pc, 32'h14);
        cycle(1'b0, 32'h0, 1'b1);
        check("redir_next", out_pc, 32'h18);

        // Misaligned redirect: sticky fault, queue drains, later redirects ignored.
        cycle(1'b1, 32'h26, 1'b1);
        check("mis_fault", {31'd0, misalign_fault}, 32'd1);
        check("mis_empty", {31'd0, out_valid}, 32'd0);
        cycle(1'b1, 32'h40, 1'b1);
        check("mis_ignored", imem_addr, 32'h1C);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        check("mis_still_empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while full with a redirect pending.
        apply_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        out_ready      = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_valid_drop", {31'd0, out_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        reset          = 1'b0;
        check("async_restart_pc", imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("async_first", out_pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            if (mfault && ($urandom_range(0, 7) == 0)) begin
                apply_reset();
            end
            rv  = ($urandom_range(0, 9) == 0);
            rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) rpc[31:10] = 22'h3F_FFFF;
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rpc, rdy);
        end
        check_outputs();

        // Wrap instance: high reset PC rolls over to zero.
        reset2 = 1'b0;
        check("wrap_rst_valid", {31'd0, out_valid2}, 32'd0);
        @(negedge clk);
        check("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
        check("wrap_pc0_p4", out_pc_plus4_2, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
        check("wrap_pc1_p4", out_pc_plus4_2, 32'h0000_0000);
        check("wrap_instr1", out_instr2, mem_word(32'hFFFF_FFFC));
        @(negedge clk);
        check("wrap_pc2", out_pc2, 32'h0000_0000);
        check("wrap_valid", {31'd0, out_valid2}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
